// File: rtl/npu_host_master.sv
// Host-side command sequencer for the NPU block-RAM bus: single writes,
// single reads, and bounded polling of a status word until bit0 is set.
module npu_host_master #(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned POLL_MAX = 1023
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        ena,
  output logic        wea,
  output logic [15:0] addra,
  output logic [31:0] dina,
  input  logic [31:0] douta
);

  typedef enum logic [2:0] {
    IDLE, WR, RD_REQ, RD_WAIT, PL_REQ, PL_WAIT, RESP
  } state_t;

  localparam logic [2:0]  WAIT_LOAD  = 3'(RD_LAT - 1);
  localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

  state_t      state, state_n;
  logic [15:0] addr_q;
  logic [31:0] data_q;
  logic [2:0]  wcnt;
  logic [15:0] pcnt;
  logic [15:0] pcnt_inc;
  logic        accept;
  logic [15:0] addr_src;
  logic [31:0] data_src;

  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    accept   = cmd_valid && cmd_ready;
    pcnt_inc = pcnt + 16'd1;
    // Bus outputs are registered from the next state, so the accept edge
    // must take address/data straight from the command inputs.
    addr_src = (state == IDLE) ? cmd_addr : addr_q;
    data_src = (state == IDLE) ? cmd_data : data_q;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            2'b00:   state_n = WR;
            2'b01:   state_n = RD_REQ;
            2'b10:   state_n = PL_REQ;
            default: state_n = IDLE;
          endcase
        end
      end
      WR:      state_n = IDLE;
      RD_REQ:  state_n = RD_WAIT;
      RD_WAIT: if (wcnt == '0) state_n = RESP;
      PL_REQ:  state_n = PL_WAIT;
      PL_WAIT: begin
        if (wcnt == '0) begin
          if (douta[0] || (pcnt_inc == POLL_LIMIT)) state_n = RESP;
          else                                      state_n = PL_REQ;
        end
      end
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wcnt        <= '0;
      pcnt        <= '0;
      ena         <= 1'b0;
      wea         <= 1'b0;
      addra       <= '0;
      dina        <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      cmd_ready <= (state_n == IDLE);

      if (accept) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        pcnt   <= '0;
      end else if (state == PL_WAIT && wcnt == '0) begin
        pcnt <= pcnt_inc;
      end

      if (state == RD_REQ || state == PL_REQ) wcnt <= WAIT_LOAD;
      else if (wcnt != '0)                    wcnt <= wcnt - 3'd1;

      ena   <= (state_n == WR) || (state_n == RD_REQ) || (state_n == PL_REQ);
      wea   <= (state_n == WR);
      addra <= (state_n == WR || state_n == RD_REQ || state_n == PL_REQ) ? addr_src : '0;
      dina  <= (state_n == WR) ? data_src : '0;

      if (state != RESP && state_n == RESP) begin
        rsp_valid   <= 1'b1;
        rsp_data    <= douta;
        rsp_timeout <= (state == PL_WAIT) && !douta[0];
      end else if (state == RESP && state_n == IDLE) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_npu_host_master.sv
// Directed bench for npu_host_master: a default instance plus a POLL_MAX=3
// instance for the poll-timeout case, each with a small BRAM read model.
module tb_npu_host_master;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid0 = 1'b0, cmd_valid1 = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_ready = 1'b0;

  logic        cmd_ready0, rsp_valid0, rsp_timeout0, busy0, ena0, wea0;
  logic [31:0] rsp_data0, dina0;
  logic [15:0] addra0;
  logic [31:0] douta0 = '0;
  logic        cmd_ready1, rsp_valid1, rsp_timeout1, busy1, ena1, wea1;
  logic [31:0] rsp_data1, dina1;
  logic [15:0] addra1;
  logic [31:0] douta1 = '0;

  int errors = 0;
  int checks = 0;
  int rd0 = 0, wr0 = 0, rd1 = 0, p0 = 0;
  logic model_clr = 1'b0;

  always #5 clk = ~clk;

  npu_host_master #(.RD_LAT(1), .POLL_MAX(1023)) dut0 (
    .clk(clk), .rst_ni(rst_ni), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0),
    .rsp_timeout(rsp_timeout0), .busy(busy0), .ena(ena0), .wea(wea0),
    .addra(addra0), .dina(dina0), .douta(douta0)
  );

  npu_host_master #(.RD_LAT(1), .POLL_MAX(3)) dut1 (
    .clk(clk), .rst_ni(rst_ni), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1),
    .rsp_timeout(rsp_timeout1), .busy(busy1), .ena(ena1), .wea(wea1),
    .addra(addra1), .dina(dina1), .douta(douta1)
  );

  // One-cycle-latency read model; the 0x5000 status word reads 1 on its 4th read.
  always @(posedge clk) begin
    if (ena0 && !wea0) begin
      rd0 <= rd0 + 1;
      if (addra0 == 16'h6000)      douta0 <= 32'h00ABCDEF;
      else if (addra0 == 16'h5000) douta0 <= (p0 == 3) ? 32'd1 : 32'd0;
      else                         douta0 <= 32'd0;
      if (addra0 == 16'h5000) p0 <= p0 + 1;
    end
    if (ena0 && wea0) wr0 <= wr0 + 1;
    if (model_clr) p0 <= 0;
    if (ena1 && !wea1) rd1 <= rd1 + 1;
    douta1 <= 32'd0;
  end

  task automatic clear_model();
    @(negedge clk) model_clr = 1'b1;
    @(negedge clk) model_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ena0, wea0, addra0, dina0} !== 50'd0) begin
      errors++; $display("FAIL reset_bus: got ena=%b wea=%b addra=%h dina=%h, want all 0", ena0, wea0, addra0, dina0);
    end
    checks++;
    if ({rsp_valid0, rsp_data0, rsp_timeout0} !== 34'd0) begin
      errors++; $display("FAIL reset_rsp: got v=%b d=%h t=%b, want 0", rsp_valid0, rsp_data0, rsp_timeout0);
    end
    checks++;
    if (busy0 !== 1'b0 || cmd_ready0 !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got busy=%b cmd_ready=%b, want 0 0", busy0, cmd_ready0);
    end
    rst_ni = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++; $display("FAIL reset_release: got cmd_ready=%b busy=%b, want 1 0", cmd_ready0, busy0);
    end
  endtask

  task automatic test_write();
    int w;
    w = wr0;
    cmd_valid0 = 1'b1; cmd_op = 2'b00; cmd_addr = 16'h1000; cmd_data = 32'h00030201;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    checks++;
    if ({ena0, wea0, addra0, dina0} !== {1'b1, 1'b1, 16'h1000, 32'h00030201}) begin
      errors++; $display("FAIL write_pulse: got ena=%b wea=%b addra=%h dina=%h, want 1 1 1000 00030201", ena0, wea0, addra0, dina0);
    end
    checks++;
    if (cmd_ready0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL write_busy: got cmd_ready=%b busy=%b, want 0 1", cmd_ready0, busy0);
    end
    @(negedge clk);
    checks++;
    if (ena0 !== 1'b0 || cmd_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
      errors++; $display("FAIL write_done: got ena=%b cmd_ready=%b rsp_valid=%b, want 0 1 0", ena0, cmd_ready0, rsp_valid0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr0 - w !== 1) begin
      errors++; $display("FAIL write_count: got %0d write pulses, want 1", wr0 - w);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    w = wr0;
    cmd_valid0 = 1'b1; cmd_op = 2'b00; cmd_addr = 16'h1004; cmd_data = 32'hA5A5_0001;
    @(negedge clk);
    checks++;
    if ({ena0, wea0, addra0, dina0} !== {1'b1, 1'b1, 16'h1004, 32'hA5A5_0001}) begin
      errors++; $display("FAIL b2b_first: got ena=%b wea=%b addra=%h dina=%h, want 1 1 1004 a5a50001", ena0, wea0, addra0, dina0);
    end
    cmd_addr = 16'h1008; cmd_data = 32'h5A5A_0002;
    @(negedge clk);
    checks++;
    if (ena0 !== 1'b0 || cmd_ready0 !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: got ena=%b cmd_ready=%b, want 0 1", ena0, cmd_ready0);
    end
    @(negedge clk);
    cmd_valid0 = 1'b0;
    checks++;
    if ({ena0, wea0, addra0, dina0} !== {1'b1, 1'b1, 16'h1008, 32'h5A5A_0002}) begin
      errors++; $display("FAIL b2b_second: got ena=%b wea=%b addra=%h dina=%h, want 1 1 1008 5a5a0002", ena0, wea0, addra0, dina0);
    end
    @(negedge clk);
    checks++;
    if (ena0 !== 1'b0 || wr0 - w !== 2) begin
      errors++; $display("FAIL b2b_count: got ena=%b pulses=%0d, want 0 2", ena0, wr0 - w);
    end
  endtask

  task automatic test_read();
    rsp_ready = 1'b1;
    cmd_valid0 = 1'b1; cmd_op = 2'b01; cmd_addr = 16'h6000; cmd_data = 32'hFFFF_FFFF;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    checks++;
    if ({ena0, wea0, addra0, dina0, rsp_valid0} !== {1'b1, 1'b0, 16'h6000, 32'd0, 1'b0}) begin
      errors++; $display("FAIL read_req: got ena=%b wea=%b addra=%h dina=%h rsp_valid=%b, want 1 0 6000 0 0", ena0, wea0, addra0, dina0, rsp_valid0);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid0 !== 1'b0 || ena0 !== 1'b0) begin
      errors++; $display("FAIL read_wait: got rsp_valid=%b ena=%b, want 0 0", rsp_valid0, ena0);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid0, rsp_data0, rsp_timeout0} !== {1'b1, 32'h00ABCDEF, 1'b0}) begin
      errors++; $display("FAIL read_rsp: got v=%b d=%h t=%b, want 1 00abcdef 0", rsp_valid0, rsp_data0, rsp_timeout0);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid0 !== 1'b0 || cmd_ready0 !== 1'b1) begin
      errors++; $display("FAIL read_done: got rsp_valid=%b cmd_ready=%b, want 0 1", rsp_valid0, cmd_ready0);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    cmd_valid0 = 1'b1; cmd_op = 2'b01; cmd_addr = 16'h6000;
    @(negedge clk);
    cmd_op = 2'b00; cmd_addr = 16'h1FFF; cmd_data = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid0, rsp_data0, rsp_timeout0, cmd_ready0, ena0} !== {1'b1, 32'h00ABCDEF, 1'b0, 1'b0, 1'b0}) begin
        errors++; $display("FAIL backpressure_hold[%0d]: got v=%b d=%h t=%b cmd_ready=%b ena=%b, want 1 00abcdef 0 0 0", i, rsp_valid0, rsp_data0, rsp_timeout0, cmd_ready0, ena0);
      end
      if (i < 4) @(negedge clk);
    end
    cmd_valid0 = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid0, cmd_ready0, busy0, ena0} !== 4'b0100) begin
      errors++; $display("FAIL backpressure_release: got v=%b cmd_ready=%b busy=%b ena=%b, want 0 1 0 0", rsp_valid0, cmd_ready0, busy0, ena0);
    end
  endtask

  task automatic test_poll();
    int r;
    bit seen;
    logic [31:0] d;
    logic t;
    clear_model();
    rsp_ready = 1'b1;
    r = rd0; seen = 0; d = '0; t = 1'b0;
    cmd_valid0 = 1'b1; cmd_op = 2'b10; cmd_addr = 16'h5000;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid0) begin seen = 1; d = rsp_data0; t = rsp_timeout0; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL poll_wait: got no rsp_valid within 60 cycles, want response");
    end
    checks++;
    if (rd0 - r !== 4) begin
      errors++; $display("FAIL poll_reads: got %0d read pulses, want 4", rd0 - r);
    end
    checks++;
    if (d !== 32'd1 || t !== 1'b0) begin
      errors++; $display("FAIL poll_rsp: got d=%h t=%b, want 00000001 0", d, t);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rd0 - r !== 4 || busy0 !== 1'b0) begin
      errors++; $display("FAIL poll_after: got pulses=%0d busy=%b, want 4 0", rd0 - r, busy0);
    end
  endtask

  task automatic test_poll_timeout();
    int r;
    bit seen;
    logic [31:0] d;
    logic t;
    rsp_ready = 1'b1;
    r = rd1; seen = 0; d = 32'hFFFF_FFFF; t = 1'b0;
    cmd_valid1 = 1'b1; cmd_op = 2'b10; cmd_addr = 16'h5000;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid1) begin seen = 1; d = rsp_data1; t = rsp_timeout1; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL timeout_wait: got no rsp_valid within 60 cycles, want response");
    end
    checks++;
    if (rd1 - r !== 3) begin
      errors++; $display("FAIL timeout_reads: got %0d read pulses, want 3", rd1 - r);
    end
    checks++;
    if (d !== 32'd0 || t !== 1'b1) begin
      errors++; $display("FAIL timeout_rsp: got d=%h t=%b, want 00000000 1", d, t);
    end
  endtask

  task automatic test_reset_mid();
    int act;
    int w;
    clear_model();
    rsp_ready = 1'b1;
    cmd_valid0 = 1'b1; cmd_op = 2'b10; cmd_addr = 16'h5000;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || ena0 !== 1'b0) begin
      errors++; $display("FAIL midrst_pre: got busy=%b ena=%b, want 1 0", busy0, ena0);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({ena0, wea0, addra0, dina0, busy0, cmd_ready0, rsp_valid0} !== 53'd0) begin
      errors++; $display("FAIL midrst_async: got ena=%b wea=%b addra=%h dina=%h busy=%b cmd_ready=%b v=%b, want all 0", ena0, wea0, addra0, dina0, busy0, cmd_ready0, rsp_valid0);
    end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (ena0 || rsp_valid0) act++;
    end
    checks++;
    if (act !== 0) begin
      errors++; $display("FAIL midrst_quiet: got %0d active cycles after release, want 0", act);
    end
    w = wr0;
    cmd_valid0 = 1'b1; cmd_op = 2'b00; cmd_addr = 16'h2000; cmd_data = 32'h0000_0055;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    checks++;
    if ({ena0, wea0, addra0, dina0} !== {1'b1, 1'b1, 16'h2000, 32'h0000_0055}) begin
      errors++; $display("FAIL midrst_write: got ena=%b wea=%b addra=%h dina=%h, want 1 1 2000 00000055", ena0, wea0, addra0, dina0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr0 - w !== 1 || cmd_ready0 !== 1'b1) begin
      errors++; $display("FAIL midrst_after: got pulses=%0d cmd_ready=%b, want 1 1", wr0 - w, cmd_ready0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_read();
    test_backpressure();
    test_poll();
    test_poll_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
